// File: rtl/fetch_unit_pkg.sv
`default_nettype none
// =============================================================================
//  Module      : fetch_unit_pkg
//  Description : Shared fetch-stage types and constants.
//  Revision    : 1.0 - initial release
// =============================================================================
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } fetch_state_t;

    localparam int unsigned INSTR_BYTES = 4;

    // Canonical addi x0,x0,0; kept for future bubble insertion in decode.
    localparam logic [31:0] NOP = 32'h0000_0013;

endpackage : fetch_unit_pkg
`default_nettype wire

// File: rtl/fetch_unit_if.sv
`default_nettype none
// =============================================================================
//  Module      : fetch_unit_if
//  Description : Instruction-memory, redirect and decode handshake bundle.
//  Revision    : 1.0 - initial release
// =============================================================================
interface fetch_unit_if #(
    parameter int XLEN = 32
);
    logic            imem_req;
    logic [XLEN-1:0] imem_addr;
    logic            imem_rvalid;
    logic [XLEN-1:0] imem_rdata;
    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;
    logic            instr_valid;
    logic            dec_ready;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
    logic [31:0]     instr_count;

    // master: the fetch unit; slave: memory, execute and decode side
    modport master (
        output imem_req,
        output imem_addr,
        input  imem_rvalid,
        input  imem_rdata,
        input  redirect_valid,
        input  redirect_pc,
        output instr_valid,
        input  dec_ready,
        output instr,
        output pc,
        output instr_count
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_rvalid,
        output imem_rdata,
        output redirect_valid,
        output redirect_pc,
        input  instr_valid,
        output dec_ready,
        input  instr,
        input  pc,
        input  instr_count
    );

endinterface : fetch_unit_if
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// =============================================================================
//  Module      : fetch_unit
//  Description : Single-outstanding instruction fetch with redirect and
//                valid/ready hand-off to decode.
//  Revision    : 1.0 - initial release
// =============================================================================
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    fetch_unit_if.master bus
);

    fetch_state_t    r_state;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc_out;
    logic            r_valid;
    logic [31:0]     r_count;

    logic [XLEN-1:0] w_redir_pc;
    logic [XLEN-1:0] w_pc_next;

    assign w_redir_pc = bus.redirect_pc & ~XLEN'(3);
    assign w_pc_next  = r_pc + XLEN'(INSTR_BYTES);

    // Request is combinational so a same-cycle redirect can suppress it;
    // rst_n gating keeps the strobe low while reset is held.
    assign bus.imem_req    = rst_n && (r_state == FETCH) && !bus.redirect_valid;
    assign bus.imem_addr   = r_pc;
    assign bus.instr_valid = r_valid;
    assign bus.instr       = r_instr;
    assign bus.pc          = r_pc_out;
    assign bus.instr_count = r_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= FETCH;
            r_pc     <= RESET_PC;
            r_instr  <= '0;
            r_pc_out <= '0;
            r_valid  <= 1'b0;
            r_count  <= '0;
        end else begin
            case (r_state)
                FETCH: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end else begin
                        r_state <= WAIT;
                    end
                end

                WAIT: begin
                    if (bus.redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_state <= bus.imem_rvalid ? FETCH : DRAIN;
                    end else if (bus.imem_rvalid) begin
                        r_instr  <= bus.imem_rdata;
                        r_pc_out <= r_pc;
                        r_valid  <= 1'b1;
                        r_state  <= HOLD;
                    end
                end

                HOLD: begin
                    // A redirect kills the held instruction even if decode takes it now.
                    if (bus.redirect_valid) begin
                        r_pc    <= w_redir_pc;
                        r_valid <= 1'b0;
                        r_state <= FETCH;
                    end else if (bus.dec_ready) begin
                        r_pc    <= w_pc_next;
                        r_valid <= 1'b0;
                        r_count <= r_count + 32'd1;
                        r_state <= FETCH;
                    end
                end

                DRAIN: begin
                    if (bus.redirect_valid) begin
                        r_pc <= w_redir_pc;
                    end
                    if (bus.imem_rvalid) begin
                        r_state <= FETCH;
                    end
                end

                default: r_state <= FETCH;
            endcase
        end
    end

endmodule : fetch_unit
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// =============================================================================
//  Module      : tb_fetch_unit
//  Description : Directed scoreboard bench for fetch_unit with a latency-
//                programmable instruction memory model.
//  Revision    : 1.0 - initial release
// =============================================================================
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0100;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_unit_if #(.XLEN(32)) bus ();

    fetch_unit #(
        .XLEN     (32),
        .RESET_PC (RST_PC)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    exp_t        sb[$];
    logic [31:0] req_log[$];

    logic [31:0] exp_pc, exp_count, req_addr;
    bit          busy, stale, exp_valid;

    bit          mem_pend;
    int          mem_cnt;
    int          lat = 1;
    logic [31:0] mem_data;
    bit          fix_en = 1'b0;
    logic [31:0] fix_data = 32'h0;

    bit          obs_req, obs_valid;
    logic [31:0] obs_addr, obs_instr, obs_pc, obs_count;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] data_for(input logic [31:0] addr);
        return fix_en ? fix_data : (addr ^ 32'hCAFE_0000);
    endfunction

    task automatic model_reset();
        exp_pc    = RST_PC;
        exp_count = 32'h0;
        busy      = 1'b0;
        stale     = 1'b0;
        exp_valid = 1'b0;
        mem_pend  = 1'b0;
        sb.delete();
    endtask

    task automatic reset_checks();
        chk("rst_imem_req",    {31'b0, bus.imem_req},    32'h0);
        chk("rst_imem_addr",   bus.imem_addr,            RST_PC);
        chk("rst_instr_valid", {31'b0, bus.instr_valid}, 32'h0);
        chk("rst_instr",       bus.instr,                32'h0);
        chk("rst_pc",          bus.pc,                   32'h0);
        chk("rst_instr_count", bus.instr_count,          32'h0);
    endtask

    // Asserts reset between clock edges so the checks prove it is asynchronous.
    task automatic reset_pulse();
        #3;
        rst_n              = 1'b0;
        bus.imem_rvalid    = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.dec_ready      = 1'b0;
        model_reset();
        #1;
        reset_checks();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // One clock cycle: drive at the falling edge, sample 1 ns later, then
    // advance the reference model to what the coming rising edge should do.
    task automatic step(input bit rdy, input bit redir, input logic [31:0] tgt);
        bit   rv;
        exp_t e;
        rv = 1'b0;
        if (mem_pend) begin
            mem_cnt--;
            if (mem_cnt == 0) begin
                rv       = 1'b1;
                mem_pend = 1'b0;
            end
        end
        bus.imem_rvalid    = rv;
        bus.imem_rdata     = rv ? mem_data : 32'hDEAD_BEEF;
        bus.dec_ready      = rdy;
        bus.redirect_valid = redir;
        bus.redirect_pc    = tgt;
        #1;
        obs_req   = bus.imem_req;
        obs_addr  = bus.imem_addr;
        obs_valid = bus.instr_valid;
        obs_instr = bus.instr;
        obs_pc    = bus.pc;
        obs_count = bus.instr_count;

        chk("imem_req", {31'b0, obs_req}, {31'b0, (!busy && !redir)});
        if (obs_req) begin
            chk("imem_addr", obs_addr, exp_pc);
            req_log.push_back(obs_addr);
            req_addr = obs_addr;
            busy     = 1'b1;
            stale    = 1'b0;
            mem_pend = 1'b1;
            mem_cnt  = lat;
            mem_data = data_for(obs_addr);
        end
        chk("instr_valid", {31'b0, obs_valid}, {31'b0, exp_valid});
        if (exp_valid && sb.size() > 0) begin
            chk("instr", obs_instr, sb[0].ins);
            chk("pc",    obs_pc,    sb[0].pc);
        end
        chk("instr_count", obs_count, exp_count);

        if (redir) begin
            exp_pc = {tgt[31:2], 2'b00};
            if (exp_valid) begin
                void'(sb.pop_front());
                exp_valid = 1'b0;
                busy      = 1'b0;
            end else if (busy) begin
                if (rv) begin
                    busy  = 1'b0;
                    stale = 1'b0;
                end else begin
                    stale = 1'b1;
                end
            end
        end else if (exp_valid) begin
            if (rdy) begin
                void'(sb.pop_front());
                exp_count = exp_count + 32'd1;
                exp_pc    = exp_pc + 32'd4;
                exp_valid = 1'b0;
                busy      = 1'b0;
            end
        end else if (rv && busy) begin
            if (stale) begin
                busy  = 1'b0;
                stale = 1'b0;
            end else begin
                e.pc  = req_addr;
                e.ins = mem_data;
                sb.push_back(e);
                exp_valid = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic run_until_req(input int max);
        for (int i = 0; i < max; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (obs_req) break;
        end
        chk("wait_req", {31'b0, obs_req}, 32'h1);
    endtask

    task automatic run_until_valid(input int max);
        for (int i = 0; i < max; i++) begin
            step(1'b0, 1'b0, 32'h0);
            if (obs_valid) break;
        end
        chk("wait_valid", {31'b0, obs_valid}, 32'h1);
    endtask

    initial begin
        bus.imem_rvalid    = 1'b0;
        bus.imem_rdata     = 32'h0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = 32'h0;
        bus.dec_ready      = 1'b0;
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        reset_checks();
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back fetch at latency 1 with decode always ready
        lat = 1;
        req_log.delete();
        repeat (9) step(1'b1, 1'b0, 32'h0);
        chk("t1_nreq",  req_log.size(), 32'd3);
        chk("t1_addr0", req_log[0], 32'h0000_0100);
        chk("t1_addr1", req_log[1], 32'h0000_0104);
        chk("t1_addr2", req_log[2], 32'h0000_0108);
        chk("t1_count", bus.instr_count, 32'd3);

        // Latency 4 with a fixed instruction word
        reset_pulse();
        lat      = 4;
        fix_en   = 1'b1;
        fix_data = 32'h0050_0513;
        run_until_req(4);
        run_until_valid(10);
        chk("t2_instr", obs_instr, 32'h0050_0513);
        chk("t2_pc",    obs_pc,    32'h0000_0100);

        // Decode stalls for 5 cycles, then accepts
        repeat (5) step(1'b0, 1'b0, 32'h0);
        chk("t3_instr", obs_instr, 32'h0050_0513);
        chk("t3_pc",    obs_pc,    32'h0000_0100);
        chk("t3_count", obs_count, 32'd0);
        lat = 3;
        step(1'b1, 1'b0, 32'h0);
        run_until_req(4);
        chk("t3_next_addr", obs_addr, 32'h0000_0104);

        // Redirect to an unaligned target while waiting; stale reply arrives later
        step(1'b0, 1'b1, 32'h0000_0203);
        step(1'b0, 1'b0, 32'h0);
        step(1'b0, 1'b0, 32'h0);
        run_until_req(4);
        chk("t4_addr", obs_addr, 32'h0000_0200);

        // Redirect in HOLD coincident with dec_ready drops the instruction
        fix_en = 1'b0;
        run_until_valid(10);
        step(1'b1, 1'b1, 32'h0000_0040);
        run_until_req(4);
        chk("t5_addr",  obs_addr,  32'h0000_0040);
        chk("t5_count", obs_count, 32'd1);

        // PC wrap from the top of the address space
        lat = 1;
        step(1'b0, 1'b1, 32'hFFFF_FFFF);
        run_until_req(8);
        chk("t6_top_addr", obs_addr, 32'hFFFF_FFFC);
        run_until_valid(4);
        chk("t6_pc", obs_pc, 32'hFFFF_FFFC);
        step(1'b1, 1'b0, 32'h0);
        run_until_req(4);
        chk("t6_wrap_addr", obs_addr, 32'h0000_0000);
        chk("t6_count",     obs_count, 32'd2);

        // Asynchronous reset while a request is outstanding
        reset_pulse();
        req_log.delete();
        repeat (3) step(1'b1, 1'b0, 32'h0);
        chk("t7_addr",  req_log[0], RST_PC);
        chk("t7_count", bus.instr_count, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_fetch_unit
`default_nettype wire
